// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencing FSM state encoding, the x0 register index and a
// helper that sizes the mul/div watchdog counter.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    // Register index of x0; wide enough for any practical register width.
    localparam logic [31:0] REG_X0 = '0;

    // Width of a counter that must reach maxCycles-1; never narrower than 1 bit.
    function automatic int cntWidth(input int maxCycles);
        return (maxCycles > 1) ? $clog2(maxCycles) : 1;
    endfunction

endpackage

// File: rtl/hazard_perf_ctr.sv
// Performance counters for the hazard controller: one counter of stall
// cycles and one of branch flushes, each wrapping modulo 2^32.
// Only present when HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_ctr (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stallInc_i,
    input  logic        flushInc_i,
    output logic [31:0] stallCnt_o,
    output logic [31:0] flushCnt_o
);

    logic [31:0] stallCnt_q;
    logic [31:0] stallCnt_d;
    logic [31:0] flushCnt_q;
    logic [31:0] flushCnt_d;

    // Next counter values: add one whenever the matching enable is high.
    always_comb begin
        stallCnt_d = stallInc_i ? stallCnt_q + 32'd1 : stallCnt_q;
        flushCnt_d = flushInc_i ? flushCnt_q + 32'd1 : flushCnt_q;
    end

    // Counter registers, cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign stallCnt_o = stallCnt_q;
    assign flushCnt_o = flushCnt_q;

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Produces stall/flush controls for the F/D/E/M/W pipeline registers,
// covering load-use bubbles, taken-branch flushes, the multi-cycle mul/div
// wait (with a watchdog) and the data-memory wait.
// A registered FSM remembers the long waits; every stall/flush output is
// combinational from that state and the current inputs.
// Optional feature: define HAZARD_PERF_EN to add the stall/flush counters
// (hazard_perf_ctr); otherwise the counter outputs read zero.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int MD_MAX_CYCLES = 40
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] rs1D_i,
    input  logic [REG_AW-1:0] rs2D_i,
    input  logic [REG_AW-1:0] rdE_i,
    input  logic              memreadE_i,
    input  logic              pcsrcE_i,
    input  logic              mdstartE_i,
    input  logic              md_done_i,
    input  logic              dmem_reqM_i,
    input  logic              dmem_readyM_i,
    output logic              stallF_o,
    output logic              stallD_o,
    output logic              stallE_o,
    output logic              stallM_o,
    output logic              flushD_o,
    output logic              flushE_o,
    output logic              flushM_o,
    output logic              flushW_o,
    output logic              md_abort_o,
    output logic              md_timeout_o,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_flush_cnt_o
);

    localparam int                CNT_W    = cntWidth(MD_MAX_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MD_MAX_CYCLES - 1);
    localparam logic [REG_AW-1:0] X0       = REG_X0[REG_AW-1:0];

    state_e           state_q;
    state_e           state_d;
    state_e           retState_q;
    state_e           retState_d;
    state_e           effState;
    logic [CNT_W-1:0] mdCnt_q;
    logic [CNT_W-1:0] mdCnt_d;
    logic             mdTimeout_q;
    logic             mdTimeout_d;
    logic             memWait;
    logic             loadUse;

    // A pending dmem access and the load-use match are pure input decodes.
    // While in MEM_WAIT with the access finished, the controller behaves as
    // the state it will return to, so that state's hazards still apply.
    always_comb begin
        memWait  = dmem_reqM_i & ~dmem_readyM_i;
        loadUse  = memreadE_i & (rdE_i != X0) &
                   ((rdE_i == rs1D_i) | (rdE_i == rs2D_i));
        effState = (state_q == MEM_WAIT) ? retState_q : state_q;
    end

    // Next-state and output logic, prioritised dmem wait, then mul/div,
    // then branch, then load-use; reset forces the safe flush pattern last.
    always_comb begin
        state_d     = state_q;
        retState_d  = retState_q;
        mdCnt_d     = mdCnt_q;
        mdTimeout_d = mdTimeout_q;
        stallF_o    = 1'b0;
        stallD_o    = 1'b0;
        stallE_o    = 1'b0;
        stallM_o    = 1'b0;
        flushD_o    = 1'b0;
        flushE_o    = 1'b0;
        flushM_o    = 1'b0;
        flushW_o    = 1'b0;
        md_abort_o  = 1'b0;

        if (memWait) begin
            stallF_o = 1'b1;
            stallD_o = 1'b1;
            stallE_o = 1'b1;
            stallM_o = 1'b1;
            flushW_o = 1'b1;
            state_d  = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                retState_d = (state_q == MD_BUSY && !md_done_i) ? MD_BUSY : RUN;
            end else if (retState_q == MD_BUSY && md_done_i) begin
                retState_d = RUN;
            end
        end else if (effState == MD_BUSY) begin
            if (md_done_i) begin
                state_d = RUN;
            end else begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                stallE_o = 1'b1;
                flushM_o = 1'b1;
                if (mdCnt_q == CNT_LAST) begin
                    md_abort_o  = 1'b1;
                    mdTimeout_d = 1'b1;
                    state_d     = RUN;
                end else begin
                    mdCnt_d = mdCnt_q + CNT_W'(1);
                    state_d = MD_BUSY;
                end
            end
        end else begin
            state_d = RUN;
            if (mdstartE_i) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                stallE_o = 1'b1;
                flushM_o = 1'b1;
                mdCnt_d  = '0;
                state_d  = MD_BUSY;
            end else if (pcsrcE_i) begin
                flushD_o = 1'b1;
                flushE_o = 1'b1;
            end else if (loadUse) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                flushE_o = 1'b1;
            end
        end

        if (!rst_n_i) begin
            stallF_o   = 1'b0;
            stallD_o   = 1'b0;
            stallE_o   = 1'b0;
            stallM_o   = 1'b0;
            flushD_o   = 1'b1;
            flushE_o   = 1'b1;
            flushM_o   = 1'b1;
            flushW_o   = 1'b1;
            md_abort_o = 1'b0;
        end
    end

    // State, return-state, watchdog counter and sticky timeout registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            retState_q  <= RUN;
            mdCnt_q     <= '0;
            mdTimeout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            retState_q  <= retState_d;
            mdCnt_q     <= mdCnt_d;
            mdTimeout_q <= mdTimeout_d;
        end
    end

    assign md_timeout_o = mdTimeout_q;

`ifdef HAZARD_PERF_EN
    // A branch flush is the only source of flushD outside reset.
    logic stallInc;
    logic flushInc;

    assign stallInc = stallF_o;
    assign flushInc = rst_n_i & flushD_o;

    hazard_perf_ctr u_perf (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .stallInc_i (stallInc),
        .flushInc_i (flushInc),
        .stallCnt_o (perf_stall_cnt_o),
        .flushCnt_o (perf_flush_cnt_o)
    );
`else
    assign perf_stall_cnt_o = 32'd0;
    assign perf_flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl.
// Two instances share the stimulus: dutMain uses the default watchdog limit,
// dutWd uses MD_MAX_CYCLES=4 so the watchdog can be exercised quickly.
// Output vectors are packed as
// {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, md_abort}.
module tb_hazard_ctrl;

    localparam logic [8:0] OUT_IDLE  = 9'b0000_0000_0;
    localparam logic [8:0] OUT_RST   = 9'b0000_1111_0;
    localparam logic [8:0] OUT_LU    = 9'b1100_0100_0;
    localparam logic [8:0] OUT_BR    = 9'b0000_1100_0;
    localparam logic [8:0] OUT_MD    = 9'b1110_0010_0;
    localparam logic [8:0] OUT_MEM   = 9'b1111_0001_0;
    localparam logic [8:0] OUT_ABORT = 9'b1110_0010_1;

    logic       clk = 1'b0;
    logic       rstN;
    logic [4:0] rs1D;
    logic [4:0] rs2D;
    logic [4:0] rdE;
    logic       memreadE;
    logic       pcsrcE;
    logic       mdstartE;
    logic       mdDone;
    logic       dmemReqM;
    logic       dmemReadyM;

    logic        mStallF, mStallD, mStallE, mStallM;
    logic        mFlushD, mFlushE, mFlushM, mFlushW;
    logic        mAbort, mTimeout;
    logic [31:0] mPerfStall, mPerfFlush;

    logic        wStallF, wStallD, wStallE, wStallM;
    logic        wFlushD, wFlushE, wFlushM, wFlushW;
    logic        wAbort, wTimeout;
    logic [31:0] wPerfStall, wPerfFlush;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .MD_MAX_CYCLES(40)) dutMain (
        .clk_i            (clk),
        .rst_n_i          (rstN),
        .rs1D_i           (rs1D),
        .rs2D_i           (rs2D),
        .rdE_i            (rdE),
        .memreadE_i       (memreadE),
        .pcsrcE_i         (pcsrcE),
        .mdstartE_i       (mdstartE),
        .md_done_i        (mdDone),
        .dmem_reqM_i      (dmemReqM),
        .dmem_readyM_i    (dmemReadyM),
        .stallF_o         (mStallF),
        .stallD_o         (mStallD),
        .stallE_o         (mStallE),
        .stallM_o         (mStallM),
        .flushD_o         (mFlushD),
        .flushE_o         (mFlushE),
        .flushM_o         (mFlushM),
        .flushW_o         (mFlushW),
        .md_abort_o       (mAbort),
        .md_timeout_o     (mTimeout),
        .perf_stall_cnt_o (mPerfStall),
        .perf_flush_cnt_o (mPerfFlush)
    );

    hazard_ctrl #(.REG_AW(5), .MD_MAX_CYCLES(4)) dutWd (
        .clk_i            (clk),
        .rst_n_i          (rstN),
        .rs1D_i           (rs1D),
        .rs2D_i           (rs2D),
        .rdE_i            (rdE),
        .memreadE_i       (memreadE),
        .pcsrcE_i         (pcsrcE),
        .mdstartE_i       (mdstartE),
        .md_done_i        (mdDone),
        .dmem_reqM_i      (dmemReqM),
        .dmem_readyM_i    (dmemReadyM),
        .stallF_o         (wStallF),
        .stallD_o         (wStallD),
        .stallE_o         (wStallE),
        .stallM_o         (wStallM),
        .flushD_o         (wFlushD),
        .flushE_o         (wFlushE),
        .flushM_o         (wFlushM),
        .flushW_o         (wFlushW),
        .md_abort_o       (wAbort),
        .md_timeout_o     (wTimeout),
        .perf_stall_cnt_o (wPerfStall),
        .perf_flush_cnt_o (wPerfFlush)
    );

    // Drive one cycle's inputs just after the rising edge, then move to the
    // falling edge where the combinational outputs are sampled.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic memread,
                                 input logic pcsrc, input logic mdstart,
                                 input logic done, input logic req,
                                 input logic ready);
        rs1D       = rs1;
        rs2D       = rs2;
        rdE        = rd;
        memreadE   = memread;
        pcsrcE     = pcsrc;
        mdstartE   = mdstart;
        mdDone     = done;
        dmemReqM   = req;
        dmemReadyM = ready;
        @(negedge clk);
    endtask

    task automatic endCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic useWd,
                               input logic [8:0] expected);
        logic [8:0] observed;
        if (useWd)
            observed = {wStallF, wStallD, wStallE, wStallM,
                        wFlushD, wFlushE, wFlushM, wFlushW, wAbort};
        else
            observed = {mStallF, mStallD, mStallE, mStallM,
                        mFlushD, mFlushE, mFlushM, mFlushW, mAbort};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] expPerfStall;
        logic [31:0] expPerfFlush;
`ifdef HAZARD_PERF_EN
        expPerfStall = 32'd6;
        expPerfFlush = 32'd1;
`else
        expPerfStall = 32'd0;
        expPerfFlush = 32'd0;
`endif

        // Reset: stalls low, flushes high, timeout and counters cleared.
        rstN = 1'b0;
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_outputs", 1'b0, OUT_RST);
        checkValue("reset_timeout", {31'd0, mTimeout}, 32'd0);
        checkValue("reset_perf_stall", mPerfStall, 32'd0);
        checkValue("reset_perf_flush", mPerfFlush, 32'd0);
        endCycle();
        rstN = 1'b1;
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_after_reset", 1'b0, OUT_IDLE);
        endCycle();

        // Load-use on rs1, then the non-stalling variants.
        applyStimulus(5'd3, 5'd0, 5'd3, 1, 0, 0, 0, 0, 0);
        checkOutput("loaduse_rs1", 1'b0, OUT_LU);
        endCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0);
        checkOutput("loaduse_x0", 1'b0, OUT_IDLE);
        endCycle();
        applyStimulus(5'd3, 5'd4, 5'd5, 1, 0, 0, 0, 0, 0);
        checkOutput("load_no_match", 1'b0, OUT_IDLE);
        endCycle();
        applyStimulus(5'd3, 5'd0, 5'd3, 0, 0, 0, 0, 0, 0);
        checkOutput("match_not_load", 1'b0, OUT_IDLE);
        endCycle();

        // Branch together with load-use: branch wins.
        applyStimulus(5'd3, 5'd0, 5'd3, 1, 1, 0, 0, 0, 0);
        checkOutput("branch_over_loaduse", 1'b0, OUT_BR);
        endCycle();

        // Mul/div: start plus four busy cycles stall, md_done drops them.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("md_wait_c%0d", i), 1'b0, OUT_MD);
            endCycle();
        end
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
        checkOutput("md_done_release", 1'b0, OUT_IDLE);
        endCycle();

        // Counters after the load-use, branch and mul/div sequences.
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_after_md", 1'b0, OUT_IDLE);
        checkValue("perf_stall_cnt", mPerfStall, expPerfStall);
        checkValue("perf_flush_cnt", mPerfFlush, expPerfFlush);
        endCycle();

        // md_done while running is ignored.
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
        checkOutput("md_done_in_run", 1'b0, OUT_IDLE);
        endCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("run_after_stray_done", 1'b0, OUT_IDLE);
        endCycle();

        // Watchdog with MD_MAX_CYCLES=4, starting from a clean reset.
        rstN = 1'b0;
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("wd_reset", 1'b1, OUT_RST);
        endCycle();
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("wd_busy_c%0d", i), 1'b1, OUT_MD);
            checkValue($sformatf("wd_no_timeout_c%0d", i), {31'd0, wTimeout}, 32'd0);
            endCycle();
        end
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
        checkOutput("wd_abort_c4", 1'b1, OUT_ABORT);
        endCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("wd_after_abort_%0d", i), 1'b1, OUT_IDLE);
            checkValue($sformatf("wd_timeout_sticky_%0d", i), {31'd0, wTimeout}, 32'd1);
            endCycle();
        end

        // Reset in the cycle the watchdog would fire: no abort, wait dropped.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("wd2_busy_c%0d", i), 1'b1, OUT_MD);
            endCycle();
        end
        rstN = 1'b0;
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
        checkOutput("reset_midop_wd", 1'b1, OUT_RST);
        checkOutput("reset_midop_main", 1'b0, OUT_RST);
        checkValue("timeout_before_reset_edge", {31'd0, wTimeout}, 32'd1);
        endCycle();
        rstN = 1'b1;
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("after_midop_reset_wd", 1'b1, OUT_IDLE);
        checkOutput("after_midop_reset_main", 1'b0, OUT_IDLE);
        checkValue("timeout_cleared", {31'd0, wTimeout}, 32'd0);
        endCycle();

        // Memory wait inside mul/div, then back to the mul/div wait.
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
        checkOutput("mdmem_start", 1'b0, OUT_MD);
        endCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 0);
            checkOutput($sformatf("mdmem_wait_c%0d", i), 1'b0, OUT_MEM);
            endCycle();
        end
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 1);
        checkOutput("mdmem_ready", 1'b0, OUT_MD);
        endCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
        checkOutput("mdmem_back_busy", 1'b0, OUT_MD);
        endCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
        checkOutput("mdmem_done", 1'b0, OUT_IDLE);
        endCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("mdmem_idle", 1'b0, OUT_IDLE);
        checkValue("main_no_timeout", {31'd0, mTimeout}, 32'd0);
        endCycle();

        // md_done during a dmem wait: return state becomes RUN.
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
        checkOutput("done_mem_start", 1'b0, OUT_MD);
        endCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, 0);
        checkOutput("done_mem_same_cycle", 1'b0, OUT_MEM);
        endCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1);
        checkOutput("done_mem_return_run", 1'b0, OUT_IDLE);
        endCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("done_mem_idle", 1'b0, OUT_IDLE);
        endCycle();

        // Dmem wait from RUN outranks branch and load-use; branch on release.
        applyStimulus(5'd3, 5'd0, 5'd3, 1, 1, 0, 0, 1, 0);
        checkOutput("mem_over_branch", 1'b0, OUT_MEM);
        endCycle();
        applyStimulus(5'd3, 5'd0, 5'd3, 1, 1, 0, 0, 1, 1);
        checkOutput("branch_on_mem_ready", 1'b0, OUT_BR);
        endCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("final_idle", 1'b0, OUT_IDLE);
        endCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
